// File: rtl/dl_shift_pkg.sv
// Shared types for the iterative left shifter and its right-shift companion.
package dl_shift_pkg;

    // Shift type; the right shifter reuses the same encoding for its sh_type.
    typedef enum logic {
        SH_LOGICAL = 1'b0,
        SH_ROTATE  = 1'b1
    } sh_type_e;

    // Control state of the iterative left shifter.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lshift_state_e;

endpackage : dl_shift_pkg

// File: rtl/dl_lshift_step.sv
// One log-stage of the left shifter: shift or rotate left by 2^stage when enabled.
module dl_lshift_step
    import dl_shift_pkg::*;
#(
    parameter  int unsigned NUM_BITS       = 8,
    localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic [NUM_BITS-1:0]       data_i,
    input  logic [NUM_SHIFT_BITS-1:0] stage_i,
    input  logic                      en_i,
    input  sh_type_e                  sh_type_i,
    output logic [NUM_BITS-1:0]       data_o
);

    localparam int unsigned AW = NUM_SHIFT_BITS + 1;

    logic [AW-1:0]       amt;
    logic [AW-1:0]       wrap_amt;
    logic [NUM_BITS-1:0] shl;
    logic [NUM_BITS-1:0] wrap;

    // Stage amount is 2^stage, at most NUM_BITS/2, so the wrap amount is never zero.
    always_comb begin
        amt      = AW'(1) << stage_i;
        wrap_amt = AW'(NUM_BITS) - amt;
        shl      = data_i << amt;
        wrap     = data_i >> wrap_amt;
        data_o   = data_i;
        if (en_i) begin
            data_o = (sh_type_i == SH_ROTATE) ? (shl | wrap) : shl;
        end
    end

endmodule : dl_lshift_step

// File: rtl/dl_lshift_iter.sv
// Multi-cycle left shifter/rotator: one log-stage per cycle between valid/ready handshakes.
module dl_lshift_iter
    import dl_shift_pkg::*;
#(
    parameter  int unsigned NUM_BITS       = 8,
    localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic                      sh_type,
    input  logic [NUM_BITS-1:0]       in,
    input  logic [NUM_SHIFT_BITS-1:0] shamt,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [NUM_BITS-1:0]       out
);

    localparam int unsigned SW = NUM_SHIFT_BITS;

    lshift_state_e       state_q, state_d;
    logic [NUM_BITS-1:0] data_q,  data_d;
    logic [SW-1:0]       shamt_q, shamt_d;
    sh_type_e            type_q,  type_d;
    logic [SW-1:0]       cnt_q,   cnt_d;
    logic                in_rdy_q, in_rdy_d;
    logic                out_vld_q, out_vld_d;

    logic [SW-1:0]       shamt_sel;
    logic [NUM_BITS-1:0] step_data;

    // Shift-amount bit for the current stage, without a mis-sized bit index.
    assign shamt_sel = shamt_q >> cnt_q;

    dl_lshift_step #(
        .NUM_BITS (NUM_BITS)
    ) u_step (
        .data_i    (data_q),
        .stage_i   (cnt_q),
        .en_i      (shamt_sel[0]),
        .sh_type_i (type_q),
        .data_o    (step_data)
    );

    // Next-state, datapath update and handshake flag decode.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        shamt_d  = shamt_q;
        type_d   = type_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    data_d  = in;
                    shamt_d = shamt;
                    type_d  = sh_type_e'(sh_type);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                data_d = step_data;
                cnt_d  = cnt_q + SW'(1);
                if (cnt_q == SW'(SW - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_rdy_d  = (state_d == IDLE);
        out_vld_d = (state_d == DONE);
    end

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            shamt_q   <= '0;
            type_q    <= SH_LOGICAL;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shamt_q   <= shamt_d;
            type_q    <= type_d;
            cnt_q     <= cnt_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign out     = data_q;

endmodule : dl_lshift_iter

// File: tb/tb_dl_lshift_iter.sv
// Self-checking bench for dl_lshift_iter (NUM_BITS=8) against an arithmetic reference model.
module tb_dl_lshift_iter;

    localparam int unsigned NB = 8;
    localparam int unsigned SB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic          sh_type;
    logic [NB-1:0] din;
    logic [SB-1:0] shamt;
    logic          out_vld;
    logic          out_rdy;
    logic [NB-1:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    dl_lshift_iter #(.NUM_BITS(NB)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .sh_type (sh_type),
        .in      (din),
        .shamt   (shamt),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out     (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: whole-amount shift/rotate in plain integer arithmetic.
    function automatic int model(input int v, input int s, input bit rot);
        int r;
        r = (v << s) & 32'hFF;
        if (rot) r = r | ((v >> (NB - s)) & 32'hFF);
        return r;
    endfunction

    // One full operation: accept, fixed latency, optional backpressure, release.
    task automatic run_op(input int v, input int s, input bit rot, input int stall, input string tag);
        int exp;
        logic [NB-1:0] held;
        exp = model(v, s, rot);
        @(negedge clk);
        chk({tag, ".in_rdy_idle"}, 32'(in_rdy), 1);
        in_vld  = 1'b1;
        din     = NB'(v);
        shamt   = SB'(s);
        sh_type = rot;
        out_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_vld  = 1'b0;
        din     = NB'($urandom);
        shamt   = SB'($urandom);
        sh_type = 1'($urandom);
        for (int k = 0; k < int'(SB); k++) begin
            chk({tag, ".busy_vld"}, 32'(out_vld), 0);
            chk({tag, ".busy_rdy"}, 32'(in_rdy), 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, ".done_vld"}, 32'(out_vld), 1);
        chk({tag, ".out"}, 32'(dout), 32'(exp));
        held = NB'(exp);
        for (int k = 0; k < stall; k++) begin
            in_vld = 1'($urandom);
            din    = NB'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".stall_vld"}, 32'(out_vld), 1);
            chk({tag, ".stall_rdy"}, 32'(in_rdy), 0);
            chk({tag, ".stall_out"}, 32'(dout), 32'(held));
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_rdy = 1'b0;
        chk({tag, ".rel_rdy"}, 32'(in_rdy), 1);
        chk({tag, ".rel_vld"}, 32'(out_vld), 0);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        sh_type = 1'b0; din = '0; shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.in_rdy", 32'(in_rdy), 1);
        chk("reset.out_vld", 32'(out_vld), 0);
        chk("reset.out", 32'(dout), 0);

        run_op(8'h01, 3, 1'b0, 0, "lsl3");
        chk("lsl3.ref", 32'(model(8'h01, 3, 1'b0)), 32'h08);
        run_op(8'h81, 1, 1'b0, 0, "lsl1");
        run_op(8'h81, 1, 1'b1, 0, "rol1");
        run_op(8'hFF, 7, 1'b0, 0, "lsl7");
        run_op(8'hB4, 7, 1'b1, 0, "rol7");
        run_op(8'hA5, 0, 1'b0, 0, "zero");
        run_op(8'h3C, 5, 1'b1, 5, "bp5");

        // Reset one edge after accept aborts the op with nothing presented.
        @(negedge clk);
        in_vld = 1'b1; din = 8'h5A; shamt = 3'd2; sh_type = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort.out_vld", 32'(out_vld), 0);
        chk("abort.in_rdy", 32'(in_rdy), 1);
        chk("abort.out", 32'(dout), 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort.quiet_vld", 32'(out_vld), 0);
        end
        run_op(8'h5A, 2, 1'b0, 1, "after_abort");

        // Randomized operations with random backpressure.
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(255)), int'($urandom_range(7)),
                   1'($urandom), int'($urandom_range(3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_dl_lshift_iter
